// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tone_generator
// Purpose  : Square-wave note synthesizer. Latches a note code (1..7 = do..si),
//            inserts a silent articulation gap of GAP_CYCLES before each new
//            note, then toggles the speaker every H cycles. H comes from the
//            latched note and the live octave selection, so octave-only
//            changes take effect at the next waveform edge without a gap.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous reset, active low
//            note_in     - note code; 1..7 valid, 0 and 8..15 are rest
//            octave_keys - 00/11 middle, 01 high, 10 low
//            mute        - forces silence while high (highest priority)
//            speaker     - square-wave output
//            active      - high while a tone is sounding
//            cur_note    - latched note (0 while silent)
// Revision : 1.0 - initial release
// ============================================================================
module tone_generator #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_keys,
  input  logic       mute,
  output logic       speaker,
  output logic       active,
  output logic [3:0] cur_note
);

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    GAP    = 2'd1,
    TONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  // Base half-period per note, folded to constants at elaboration.
  function automatic logic [CNT_W-1:0] base_half(input logic [3:0] n);
    case (n)
      4'd1:    base_half = CNT_W'(CLK_FREQ / (2 * 262));
      4'd2:    base_half = CNT_W'(CLK_FREQ / (2 * 294));
      4'd3:    base_half = CNT_W'(CLK_FREQ / (2 * 330));
      4'd4:    base_half = CNT_W'(CLK_FREQ / (2 * 349));
      4'd5:    base_half = CNT_W'(CLK_FREQ / (2 * 392));
      4'd6:    base_half = CNT_W'(CLK_FREQ / (2 * 440));
      4'd7:    base_half = CNT_W'(CLK_FREQ / (2 * 494));
      default: base_half = '0;
    endcase
  endfunction

  state_t           r_state, w_state;
  logic [3:0]       r_cur_note, w_cur_note;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt;
  logic [CNT_W-1:0] r_ph_cnt, w_ph_cnt;
  logic             r_speaker, w_speaker;

  logic             w_valid;
  logic             w_new_note;
  logic [CNT_W-1:0] w_h0;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_h_last;

  assign w_valid    = (note_in != 4'd0) && (note_in <= 4'd7);
  assign w_new_note = w_valid && (note_in != r_cur_note);

  // Half-period follows octave_keys every cycle; ph_cnt is never cleared on
  // an octave change, so a shorter H simply makes the >= compare fire sooner.
  assign w_h0 = base_half(r_cur_note);
  always_comb begin
    w_h = w_h0;
    case (octave_keys)
      2'b01:   w_h = w_h0 >> 1;
      2'b10:   w_h = w_h0 << 1;
      default: w_h = w_h0;
    endcase
  end
  assign w_h_last = w_h - CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SILENT;
      r_cur_note <= 4'd0;
      r_gap_cnt  <= '0;
      r_ph_cnt   <= '0;
      r_speaker  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cur_note <= w_cur_note;
      r_gap_cnt  <= w_gap_cnt;
      r_ph_cnt   <= w_ph_cnt;
      r_speaker  <= w_speaker;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cur_note = r_cur_note;
    w_gap_cnt  = r_gap_cnt;
    w_ph_cnt   = r_ph_cnt;
    w_speaker  = r_speaker;

    case (r_state)
      SILENT: begin
        w_speaker = 1'b0;
        if (w_valid) begin
          w_state    = GAP;
          w_cur_note = note_in;
          w_gap_cnt  = '0;
        end
      end

      GAP: begin
        w_speaker = 1'b0;
        if (!w_valid) begin
          w_state    = SILENT;
          w_cur_note = 4'd0;
        end else if (w_new_note) begin
          // Re-articulation during the gap restarts the silent interval.
          w_cur_note = note_in;
          w_gap_cnt  = '0;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_state   = TONE;
          w_speaker = 1'b1;
          w_ph_cnt  = '0;
        end else begin
          w_gap_cnt = r_gap_cnt + CNT_W'(1);
        end
      end

      TONE: begin
        if (!w_valid) begin
          w_state    = SILENT;
          w_speaker  = 1'b0;
          w_cur_note = 4'd0;
        end else if (w_new_note) begin
          w_state    = GAP;
          w_speaker  = 1'b0;
          w_cur_note = note_in;
          w_gap_cnt  = '0;
        end else if (r_ph_cnt >= w_h_last) begin
          w_speaker = ~r_speaker;
          w_ph_cnt  = '0;
        end else begin
          w_ph_cnt = r_ph_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state    = SILENT;
        w_speaker  = 1'b0;
        w_cur_note = 4'd0;
      end
    endcase

    // Mute overrides every other transition.
    if (mute) begin
      w_state    = SILENT;
      w_speaker  = 1'b0;
      w_cur_note = 4'd0;
    end
  end

  assign speaker  = r_speaker;
  assign active   = (r_state == TONE);
  assign cur_note = r_cur_note;

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tone_generator
// Purpose  : Self-checking bench for tone_generator (CLK_FREQ=10000,
//            GAP_CYCLES=4): vector table, hand-written corner sequences and
//            a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_generator;

  localparam int CLK_FREQ   = 10000;
  localparam int GAP_CYCLES = 4;
  localparam int CNT_W      = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [1:0] octave_keys = 2'd0;
  logic       mute = 1'b0;
  logic       speaker;
  logic       active;
  logic [3:0] cur_note;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tone_generator #(
    .CLK_FREQ  (CLK_FREQ),
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note_in    (note_in),
    .octave_keys(octave_keys),
    .mute       (mute),
    .speaker    (speaker),
    .active     (active),
    .cur_note   (cur_note)
  );

  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    logic       mte;
    int         n;
    logic       spk;
    logic       act;
    logic [3:0] cur;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: a countdown of silent cycles, then a level that
  // flips once it has been held for the current half-period.
  int   m_note = 0;
  int   m_wait = 0;
  int   m_held = 0;
  logic m_level = 1'b0;
  logic m_sound = 1'b0;

  function automatic int half_of(input int n, input logic [1:0] o);
    int f;
    int h;
    case (n)
      1: f = 262;
      2: f = 294;
      3: f = 330;
      4: f = 349;
      5: f = 392;
      6: f = 440;
      7: f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    h = CLK_FREQ / (2 * f);
    if (o == 2'b01) h = h / 2;
    else if (o == 2'b10) h = h * 2;
    return h;
  endfunction

  task automatic model_clear();
    m_note = 0; m_wait = 0; m_held = 0; m_level = 1'b0; m_sound = 1'b0;
  endtask

  // One clock edge of the reference, using the inputs about to be sampled.
  task automatic model_step();
    int n;
    n = int'(note_in);
    if (mute || n < 1 || n > 7) begin
      model_clear();
    end else if (n != m_note) begin
      m_note = n; m_wait = GAP_CYCLES; m_sound = 1'b0; m_level = 1'b0; m_held = 0;
    end else if (!m_sound) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_sound = 1'b1; m_level = 1'b1; m_held = 0;
      end
    end else begin
      m_held = m_held + 1;
      if (m_held >= half_of(n, octave_keys)) begin
        m_level = ~m_level; m_held = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic es, input logic ea, input logic [3:0] en);
    total++;
    if (speaker !== es || active !== ea || cur_note !== en) begin
      bad++;
      $display("FAIL %s t=%0t: got spk=%0b act=%0b note=%0d, want spk=%0b act=%0b note=%0d",
               name, $time, speaker, active, cur_note, es, ea, en);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] n, input logic [1:0] o, input logic m);
    note_in = n; octave_keys = o; mute = m;
  endtask

  initial begin
    // Reset state, before any clock edge.
    #1;
    chk("reset", 1'b0, 1'b0, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // note, oct, mute, edges, speaker, active, cur_note
    tbl.push_back(vec_t'{4'd0,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 3,  1'b0, 1'b0, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 10, 1'b1, 1'b1, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 1,  1'b0, 1'b1, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 10, 1'b0, 1'b1, 4'd6});
    tbl.push_back(vec_t'{4'd6,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd6});
    tbl.push_back(vec_t'{4'd0,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd9,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd1,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd1});
    tbl.push_back(vec_t'{4'd1,  2'd0, 1'b0, 3,  1'b0, 1'b0, 4'd1});
    tbl.push_back(vec_t'{4'd1,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd1});
    tbl.push_back(vec_t'{4'd1,  2'd0, 1'b0, 18, 1'b1, 1'b1, 4'd1});
    tbl.push_back(vec_t'{4'd1,  2'd0, 1'b0, 1,  1'b0, 1'b1, 4'd1});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 3,  1'b0, 1'b0, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 14, 1'b1, 1'b1, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 1,  1'b0, 1'b1, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 14, 1'b0, 1'b1, 4'd3});
    tbl.push_back(vec_t'{4'd3,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd3});
    tbl.push_back(vec_t'{4'd15, 2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 5,  1'b1, 1'b1, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b1, 1,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b1, 6,  1'b0, 1'b0, 4'd0});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 1,  1'b0, 1'b0, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 3,  1'b0, 1'b0, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 1,  1'b1, 1'b1, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 12, 1'b0, 1'b1, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd0, 1'b0, 12, 1'b1, 1'b1, 4'd5});
    tbl.push_back(vec_t'{4'd5,  2'd3, 1'b0, 12, 1'b0, 1'b1, 4'd5});

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].note, tbl[i].oct, tbl[i].mte);
      adv(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].spk, tbl[i].act, tbl[i].cur);
    end

    // Octave changes mid-tone.
    set_in(4'd0, 2'b01, 1'b0); adv(1);
    note_in = 4'd6;
    adv(4);  chk("oct_gap", 1'b0, 1'b0, 4'd6);
    adv(1);  chk("oct_rise", 1'b1, 1'b1, 4'd6);
    adv(4);  chk("oct_hi_hold", 1'b1, 1'b1, 4'd6);
    adv(1);  chk("oct_hi_fall", 1'b0, 1'b1, 4'd6);
    adv(2);
    octave_keys = 2'b10;
    adv(19); chk("oct_lo_hold", 1'b0, 1'b1, 4'd6);
    adv(1);  chk("oct_lo_edge", 1'b1, 1'b1, 4'd6);
    adv(21); chk("oct_lo_full", 1'b1, 1'b1, 4'd6);
    adv(1);  chk("oct_lo_fall", 1'b0, 1'b1, 4'd6);
    adv(15);
    octave_keys = 2'b01;
    adv(1);  chk("oct_overrun", 1'b1, 1'b1, 4'd6);
    adv(4);  chk("oct_hi2_hold", 1'b1, 1'b1, 4'd6);
    adv(1);  chk("oct_hi2_fall", 1'b0, 1'b1, 4'd6);

    // Note change during the gap restarts it.
    set_in(4'd0, 2'b00, 1'b0); adv(1);
    note_in = 4'd2;
    adv(1);  chk("gap_start", 1'b0, 1'b0, 4'd2);
    adv(2);  chk("gap_cnt2", 1'b0, 1'b0, 4'd2);
    note_in = 4'd5;
    adv(1);  chk("gap_relatch", 1'b0, 1'b0, 4'd5);
    adv(3);  chk("gap_restart", 1'b0, 1'b0, 4'd5);
    adv(1);  chk("gap_rise", 1'b1, 1'b1, 4'd5);
    adv(11); chk("gap_hi_hold", 1'b1, 1'b1, 4'd5);
    adv(1);  chk("gap_fall", 1'b0, 1'b1, 4'd5);

    // Asynchronous reset mid-tone.
    set_in(4'd7, 2'b00, 1'b0);
    adv(5);  chk("ar_rise", 1'b1, 1'b1, 4'd7);
    adv(3);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_async", 1'b0, 1'b0, 4'd0);
    #2;
    reset = 1'b1;
    adv(1);  chk("ar_first", 1'b0, 1'b0, 4'd7);
    adv(3);  chk("ar_gap", 1'b0, 1'b0, 4'd7);
    adv(1);  chk("ar_rise2", 1'b1, 1'b1, 4'd7);
    adv(9);  chk("ar_hi_hold", 1'b1, 1'b1, 4'd7);
    adv(1);  chk("ar_fall", 1'b0, 1'b1, 4'd7);

    // Randomized run against the reference model.
    set_in(4'd0, 2'b00, 1'b0);
    #2;
    reset = 1'b0;
    model_clear();
    #2;
    reset = 1'b1;
    adv(1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) begin
        if ($urandom_range(9) < 7) note_in = 4'($urandom_range(7, 1));
        else note_in = 4'($urandom_range(15));
      end
      if ($urandom_range(29) == 0) octave_keys = 2'($urandom_range(3));
      if (mute) begin
        if ($urandom_range(9) == 0) mute = 1'b0;
      end else if ($urandom_range(299) == 0) begin
        mute = 1'b1;
      end
      model_step();
      adv(1);
      chk("rand", m_level, m_sound, 4'(m_note));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
